alu_exec_stage: RTL



---
 rtl/alu_exec_stage.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_stage.sv
// Execute stage around the 16-bit alu: registered operands in, registered result/flags out.
// Latency 2 edges from accept to out_valid; SHIFT_MULTI_EN adds one edge per extra shift bit.
// Backpressure: result held in DONE until out_ready; a new op is accepted on the releasing edge.

module alu #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ext_cin,
    input  logic [4:0]       ALUop,
    output logic [WIDTH-1:0] y,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v
);
    logic [WIDTH:0] sum;

    always_comb begin
        sum = '0;
        y   = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (ALUop)
            5'b00000: begin
                sum = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Ext_cin};
                y   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (A[WIDTH-1] == B[WIDTH-1]) && (y[WIDTH-1] != A[WIDTH-1]);
            end
            5'b00010: begin
                // c is the borrow out, so chained subtracts feed it back as Ext_cin
                sum = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, Ext_cin};
                y   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (A[WIDTH-1] != B[WIDTH-1]) && (y[WIDTH-1] != A[WIDTH-1]);
            end
            5'b00100: y = A & B;
            5'b00101: y = A | B;
            5'b00110: y = A ^ B;
            5'b00111: y = ~A;
            5'b01000: begin
                y = {A[WIDTH-2:0], 1'b0};
                c = A[WIDTH-1];
            end
            5'b01001: begin
                y = {1'b0, A[WIDTH-1:1]};
                c = A[0];
            end
            default:  y = A;
        endcase
        z = (y == '0);
        n = y[WIDTH-1];
    end
endmodule

module alu_exec_stage #(
    parameter int WIDTH = 16,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OPW-1:0]   in_op,
    input  logic             in_use_c,
    input  logic [3:0]       in_flag_we,
    input  logic [3:0]       in_shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [3:0]       out_zncv,
    output logic [3:0]       flags,
    output logic             busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
`ifdef SHIFT_MULTI_EN
        SHIFT = 2'd2,
`endif
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [OPW-1:0]   op_q, op_d;
    logic             usec_q, usec_d;
    logic [3:0]       we_q, we_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [3:0]       zncv_q, zncv_d;
    logic [3:0]       flags_q, flags_d;

    logic [WIDTH-1:0] alu_a, alu_b, alu_y;
    logic [OPW-1:0]   alu_op;
    logic             alu_cin, alu_z, alu_n, alu_c, alu_v;
    logic [3:0]       flag_new, flag_mask, flags_upd;
    logic             in_fire;

`ifdef SHIFT_MULTI_EN
    localparam logic [OPW-1:0] OP_OR  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_LSL = OPW'(5'b01000);
    localparam logic [OPW-1:0] OP_LSR = OPW'(5'b01001);
    logic [3:0] shamt_q, shamt_d, cnt_q, cnt_d;
    logic       is_shift;
`else
    logic unused_shamt;
    assign unused_shamt = ^in_shamt;
`endif

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_y     = y_q;
    assign out_zncv  = zncv_q;
    assign flags     = flags_q;
    assign in_fire   = in_valid & in_ready;

    alu #(.WIDTH(WIDTH)) u_alu (
        .A       (alu_a),
        .B       (alu_b),
        .Ext_cin (alu_cin),
        .ALUop   (alu_op),
        .y       (alu_y),
        .z       (alu_z),
        .n       (alu_n),
        .c       (alu_c),
        .v       (alu_v)
    );

    assign flag_new  = {alu_z, alu_n, alu_c, alu_v};
    assign flags_upd = (flags_q & ~flag_mask) | (flag_new & flag_mask);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        usec_d    = usec_q;
        we_d      = we_q;
        y_d       = y_q;
        zncv_d    = zncv_q;
        flags_d   = flags_q;
        alu_a     = a_q;
        alu_b     = b_q;
        alu_op    = op_q;
        alu_cin   = usec_q & flags_q[1];
        flag_mask = we_q;
`ifdef SHIFT_MULTI_EN
        shamt_d   = shamt_q;
        cnt_d     = cnt_q;
        is_shift  = (op_q == OP_LSL) || (op_q == OP_LSR);
        // Zero-length shift degenerates to a pass-through that must not touch C
        if (is_shift && (shamt_q == 4'd0)) begin
            alu_op    = OP_OR;
            alu_b     = '0;
            flag_mask = we_q & 4'b1101;
        end
`endif

        if (in_fire) begin
            a_d    = in_a;
            b_d    = in_b;
            op_d   = in_op;
            usec_d = in_use_c;
            we_d   = in_flag_we;
`ifdef SHIFT_MULTI_EN
            shamt_d = in_shamt;
`endif
        end

        case (state_q)
            IDLE: begin
                if (in_valid) state_d = EXEC;
            end
            EXEC: begin
`ifdef SHIFT_MULTI_EN
                if (is_shift && (shamt_q > 4'd1)) begin
                    a_d     = alu_y;
                    cnt_d   = shamt_q - 4'd1;
                    state_d = SHIFT;
                end else begin
                    y_d     = alu_y;
                    zncv_d  = flag_new;
                    flags_d = flags_upd;
                    state_d = DONE;
                end
`else
                y_d     = alu_y;
                zncv_d  = flag_new;
                flags_d = flags_upd;
                state_d = DONE;
`endif
            end
`ifdef SHIFT_MULTI_EN
            SHIFT: begin
                if (cnt_q == 4'd1) begin
                    y_d     = alu_y;
                    zncv_d  = flag_new;
                    flags_d = flags_upd;
                    state_d = DONE;
                end else begin
                    a_d   = alu_y;
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            DONE: begin
                if (out_ready) state_d = in_valid ? EXEC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            usec_q  <= 1'b0;
            we_q    <= '0;
            y_q     <= '0;
            zncv_q  <= '0;
            flags_q <= '0;
`ifdef SHIFT_MULTI_EN
            shamt_q <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            usec_q  <= usec_d;
            we_q    <= we_d;
            y_q     <= y_d;
            zncv_q  <= zncv_d;
            flags_q <= flags_d;
`ifdef SHIFT_MULTI_EN
            shamt_q <= shamt_d;
            cnt_q   <= cnt_d;
`endif
        end
    end
endmodule
